seq_pulse_gen: RTL and testbench

Four-phase sequential pulse generator built as a small Moore state machine. After reset it drives a single high bit that walks across a 4-bit output, one position per clock: 0001, 0010, 0100, 1000, then repeats. The same behaviour is available in three state-machine coding styles, selected by a parameter. All three must be cycle-identical, so the block also serves as the timing generator for phase-sequenced downstream logic.

---
 rtl/seq_pulse_gen.sv | 155 +++++++++++++++
 tb/tb_seq_pulse_gen.sv | 113 +++++++++++
 2 files changed

// File: rtl/seq_pulse_gen.sv
// Four-phase walking-one pulse generator (IDLE -> P0..P3 -> P0 ...).
// STYLE picks a one-, two- or three-process FSM; all three give the same q on every cycle.
`timescale 1ns / 1ps

module seq_pulse_gen #(
   parameter int STYLE = 1
) (
   input  logic       clk,
   input  logic       rst,
   output logic [3:0] q
);

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StP0   = 3'd1,
      StP1   = 3'd2,
      StP2   = 3'd3,
      StP3   = 3'd4
   } state_e;

   // State registers are plain 3-bit vectors so codes 5..7 stay representable and recoverable.
   function automatic logic [2:0] next_state(input logic [2:0] s);
      logic [2:0] n;
      n = StIdle;
      case (s)
         StIdle:  n = StP0;
         StP0:    n = StP1;
         StP1:    n = StP2;
         StP2:    n = StP3;
         StP3:    n = StP0;
         default: n = StIdle;
      endcase
      return n;
   endfunction

   function automatic logic [3:0] decode(input logic [2:0] s);
      logic [3:0] d;
      d = 4'b0000;
      case (s)
         StP0:    d = 4'b0001;
         StP1:    d = 4'b0010;
         StP2:    d = 4'b0100;
         StP3:    d = 4'b1000;
         default: d = 4'b0000;
      endcase
      return d;
   endfunction

   generate
      if (STYLE == 2) begin : g_style2
         logic [2:0] state_q;
         logic [2:0] state_d;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               state_q <= StIdle;
            end else begin
               state_q <= state_d;
            end
         end

         always_comb begin
            state_d = StIdle;
            q       = 4'b0000;
            case (state_q)
               StIdle: begin
                  state_d = StP0;
                  q       = 4'b0000;
               end
               StP0: begin
                  state_d = StP1;
                  q       = 4'b0001;
               end
               StP1: begin
                  state_d = StP2;
                  q       = 4'b0010;
               end
               StP2: begin
                  state_d = StP3;
                  q       = 4'b0100;
               end
               StP3: begin
                  state_d = StP0;
                  q       = 4'b1000;
               end
               default: begin
                  state_d = StIdle;
                  q       = 4'b0000;
               end
            endcase
         end
      end else if (STYLE == 3) begin : g_style3
         logic [2:0] state_q;
         logic [2:0] state_d;
         logic [3:0] q_q;

         always_comb begin
            state_d = next_state(state_q);
         end

         // q is decoded from state_d so it lands in the same edge as the state it describes.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               state_q <= StIdle;
               q_q     <= 4'b0000;
            end else begin
               state_q <= state_d;
               q_q     <= decode(state_d);
            end
         end

         assign q = q_q;
      end else begin : g_style1
         logic [2:0] state_q;
         logic [3:0] q_q;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               state_q <= StIdle;
               q_q     <= 4'b0000;
            end else begin
               case (state_q)
                  StIdle: begin
                     state_q <= StP0;
                     q_q     <= 4'b0001;
                  end
                  StP0: begin
                     state_q <= StP1;
                     q_q     <= 4'b0010;
                  end
                  StP1: begin
                     state_q <= StP2;
                     q_q     <= 4'b0100;
                  end
                  StP2: begin
                     state_q <= StP3;
                     q_q     <= 4'b1000;
                  end
                  StP3: begin
                     state_q <= StP0;
                     q_q     <= 4'b0001;
                  end
                  default: begin
                     state_q <= StIdle;
                     q_q     <= 4'b0000;
                  end
               endcase
            end
         end

         assign q = q_q;
      end
   endgenerate

endmodule

// File: tb/tb_seq_pulse_gen.sv
// Directed bench: three seq_pulse_gen styles side by side on one clock/reset,
// each q checked against hand-computed walking-one values.
`timescale 1ns / 1ps

module tb_seq_pulse_gen;

   logic       clk;
   logic       rst;
   logic [3:0] q1;
   logic [3:0] q2;
   logic [3:0] q3;
   int         n_checks;
   int         n_pass;
   int         cyc;
   logic [3:0] exp_q;

   seq_pulse_gen #(.STYLE(1)) dut1 (.clk(clk), .rst(rst), .q(q1));
   seq_pulse_gen #(.STYLE(2)) dut2 (.clk(clk), .rst(rst), .q(q2));
   seq_pulse_gen #(.STYLE(3)) dut3 (.clk(clk), .rst(rst), .q(q3));

   initial clk = 1'b0;
   always #2 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, expv);
   endtask

   task automatic check_all(input string tag, input logic [3:0] expv);
      check({tag, "/s1"}, q1, expv);
      check({tag, "/s2"}, q2, expv);
      check({tag, "/s3"}, q3, expv);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b0;

      // Power-up in reset across several edges.
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check_all($sformatf("por%0d", i), 4'b0000);
      end

      // Release between edges, then the first 8 edges.
      #0.5 rst = 1'b1;
      cyc = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         exp_q = 4'b0001 << (i % 4);
         check_all($sformatf("seq%0d", i), exp_q);
      end

      // Free run: bit k high exactly when (cyc-1) mod 4 == k.
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         exp_q = 4'b0001 << ((cyc - 1) % 4);
         check_all($sformatf("run%0d", cyc), exp_q);
      end

      // cyc is 58 here; next edge is cyc 59 -> 0100.
      @(posedge clk);
      #1;
      cyc++;
      check_all("pre_rst", 4'b0100);
      rst = 1'b0;
      #0.5;
      check_all("async_rst", 4'b0000);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check_all($sformatf("hold_rst%0d", i), 4'b0000);
      end
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         exp_q = 4'b0001 << (i % 4);
         check_all($sformatf("restart%0d", i), exp_q);
      end

      // Illegal state encoding: recover through IDLE, then P0.
      force dut1.g_style1.state_q = 3'b111;
      force dut2.g_style2.state_q = 3'b110;
      force dut3.g_style3.state_q = 3'b101;
      #0.5;
      release dut1.g_style1.state_q;
      release dut2.g_style2.state_q;
      release dut3.g_style3.state_q;
      #0.5;
      check("illegal_comb/s2", q2, 4'b0000);
      @(posedge clk);
      #1;
      check_all("illegal_idle", 4'b0000);
      @(posedge clk);
      #1;
      check_all("illegal_p0", 4'b0001);
      @(posedge clk);
      #1;
      check_all("illegal_p1", 4'b0010);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
